// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver: n bits (direction latched on first bit) become one registered word.
// Latency: the word is on q with v=1 right after the edge taking its n-th bit; an unacked word blocks, so a newer one is dropped and ov is set.
module shift_deserializer #(
   parameter int n = 4
) (
   input  logic         C,
   input  logic         R,
   input  logic         SI,
   input  logic         SV,
   input  logic         RTL,
   input  logic         FR,
   input  logic         A,
   output logic [n-1:0] Q,
   output logic [n-1:0] nQ,
   output logic         V,
   output logic         OV,
   output logic         BUSY
);

   localparam int CW = (n > 2) ? $clog2(n) : 1;
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   logic [n-1:0]  sh;
   logic [n-1:0]  sh_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_eff;
   logic          dir;
   logic          dir_eff;
   logic          done;
   logic          ack;

   // A frame restart makes this bit the first of a fresh word.
   always_comb begin
      cnt_eff = FR ? '0 : cnt;
      dir_eff = (cnt_eff == '0) ? RTL : dir;
      sh_nx   = dir_eff ? {sh[n-2:0], SI} : {SI, sh[n-1:1]};
      done    = SV && (cnt_eff == LAST);
      ack     = V && A;
   end

   always_ff @(posedge C) begin
      if (R) begin
         sh  <= '0;
         cnt <= '0;
         dir <= 1'b0;
         Q   <= '0;
         V   <= 1'b0;
         OV  <= 1'b0;
      end else begin
         if (SV) begin
            sh  <= sh_nx;
            dir <= dir_eff;
            cnt <= done ? '0 : cnt_eff + 1'b1;
         end else if (FR) begin
            cnt <= '0;
         end

         if (done) begin
            if (!V || ack) begin
               Q <= sh_nx;
               V <= 1'b1;
            end else begin
               OV <= 1'b1;
            end
         end else if (ack) begin
            V <= 1'b0;
         end
      end
   end

   assign nQ   = ~Q;
   assign BUSY = (cnt != '0);

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer (n=4) with hand-computed expected words.
module tb_shift_deserializer;

   logic       C = 1'b0;
   logic       R, SI, SV, RTL, FR, A;
   logic [3:0] Q, nQ;
   logic       V, OV, BUSY;
   int         total = 0;
   int         bad = 0;

   shift_deserializer #(.n(4)) dut (
      .C(C), .R(R), .SI(SI), .SV(SV), .RTL(RTL), .FR(FR), .A(A),
      .Q(Q), .nQ(nQ), .V(V), .OV(OV), .BUSY(BUSY)
   );

   always #5 C = ~C;

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic send(input logic b);
      SI = b;
      SV = 1'b1;
      tick();
      SV = 1'b0;
   endtask

   task automatic ack_pulse();
      A = 1'b1;
      tick();
      A = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      R = 1'b1; SI = 1'b0; SV = 1'b0; RTL = 1'b0; FR = 1'b0; A = 1'b0;
      tick();
      tick();
      R = 1'b0;
      chk("rst_q", Q, 4'h0);
      chk("rst_nq", nQ, 4'hF);
      chk("rst_v", V, 1'b0);
      chk("rst_ov", OV, 1'b0);
      chk("rst_busy", BUSY, 1'b0);

      // MSB-first 1,0,1,1
      RTL = 1'b1;
      send(1'b1); send(1'b0);
      chk("msb_busy_mid", BUSY, 1'b1);
      chk("msb_v_mid", V, 1'b0);
      send(1'b1); send(1'b1);
      chk("msb_q", Q, 4'b1011);
      chk("msb_nq", nQ, 4'b0100);
      chk("msb_v", V, 1'b1);
      chk("msb_busy", BUSY, 1'b0);
      ack_pulse();
      chk("msb_ack_v", V, 1'b0);
      chk("msb_ack_q", Q, 4'b1011);

      // LSB-first 1,0,1,1 with RTL flipped after the first bit
      RTL = 1'b0;
      send(1'b1);
      RTL = 1'b1;
      send(1'b0); send(1'b1); send(1'b1);
      chk("lsb_q", Q, 4'b1101);
      chk("lsb_v", V, 1'b1);
      ack_pulse();
      chk("lsb_ack_v", V, 1'b0);

      // Same word with gaps
      RTL = 1'b0;
      send(1'b1); tick();
      send(1'b0); tick(); tick();
      chk("gap_busy", BUSY, 1'b1);
      chk("gap_v_mid", V, 1'b0);
      send(1'b1); send(1'b1);
      chk("gap_q", Q, 4'b1101);
      chk("gap_v", V, 1'b1);
      ack_pulse();
      chk("gap_ack_v", V, 1'b0);
      chk("gap_ack_q", Q, 4'b1101);
      ack_pulse();
      chk("stray_ack_v", V, 1'b0);
      chk("stray_ack_q", Q, 4'b1101);

      // Overflow: 5 left unacked, then A
      RTL = 1'b1;
      send(1'b0); send(1'b1); send(1'b0); send(1'b1);
      chk("ov_q5", Q, 4'h5);
      chk("ov_ov0", OV, 1'b0);
      send(1'b1); send(1'b0); send(1'b1); send(1'b0);
      chk("ov_q", Q, 4'h5);
      chk("ov_v", V, 1'b1);
      chk("ov_ov", OV, 1'b1);
      ack_pulse();
      chk("ov_sticky", OV, 1'b1);
      chk("ov_ack_v", V, 1'b0);

      // Back-to-back with ack on completing edge
      R = 1'b1; tick(); R = 1'b0;
      chk("rst2_ov", OV, 1'b0);
      RTL = 1'b1;
      send(1'b0); send(1'b0); send(1'b1); send(1'b1);
      chk("b2b_q1", Q, 4'h3);
      send(1'b1); send(1'b1); send(1'b0);
      A = 1'b1;
      send(1'b0);
      A = 1'b0;
      chk("b2b_q2", Q, 4'hC);
      chk("b2b_v", V, 1'b1);
      chk("b2b_ov", OV, 1'b0);
      ack_pulse();

      // Frame restart after 2 bits
      send(1'b0); send(1'b0);
      FR = 1'b1; tick(); FR = 1'b0;
      chk("fr_busy", BUSY, 1'b0);
      send(1'b1); send(1'b1); send(1'b1); send(1'b1);
      chk("fr_q", Q, 4'hF);
      chk("fr_v", V, 1'b1);
      ack_pulse();

      // FR on completing edge starts a new word instead
      send(1'b0); send(1'b0); send(1'b0);
      FR = 1'b1;
      send(1'b1);
      FR = 1'b0;
      chk("frc_v", V, 1'b0);
      chk("frc_busy", BUSY, 1'b1);
      chk("frc_q", Q, 4'hF);
      send(1'b0); send(1'b1); send(1'b0);
      chk("frc_q2", Q, 4'hA);
      chk("frc_v2", V, 1'b1);

      // Reset mid-word
      send(1'b1); send(1'b1);
      R = 1'b1; tick(); R = 1'b0;
      chk("rmid_q", Q, 4'h0);
      chk("rmid_nq", nQ, 4'hF);
      chk("rmid_v", V, 1'b0);
      chk("rmid_ov", OV, 1'b0);
      chk("rmid_busy", BUSY, 1'b0);
      send(1'b1); send(1'b0); send(1'b0); send(1'b1);
      chk("post_rst_q", Q, 4'h9);
      chk("post_rst_v", V, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-in, parallel-out receiver for the serial stream produced by the team's parallel-load shift register. Collects `n` serial bits, honouring the same `RTL` shift-direction convention so words arrive in their original bit positions, and presents each completed word on a registered parallel output with a valid/acknowledge handshake. Sits at the receiving end of any serial link built from the shift register, feeding a parallel consumer.

## Interface

**Parameters**
- `n`, 4, word width in bits; legal range `n >= 2`.

**Ports**
- `C` input, 1: clock; all state changes on its rising edge.
- `R` input, 1: reset. Synchronous and active-high.
- `SI` input, 1: serial data bit.
- `SV` input, 1: `SI` is valid this cycle; one bit is consumed per cycle with `SV=1`.
- `RTL` input, 1: bit order for the current word.
  - `1` = shift left: first bit received ends in `Q[n-1]`.
  - `0` = shift right: first bit received ends in `Q[0]`.
- `FR` input, 1: frame restart; discards any partial word.
- `A` input, 1: consumer acknowledge of the presented word.
- `Q` output, n: last completed word (registered).
- `nQ` output, n: always `~Q`.
- `V` output, 1: `Q` holds an unacknowledged word.
- `OV` output, 1: sticky overflow; a completed word was dropped.
- `BUSY` output, 1: partial word in progress (bit count ≠ 0).

## Operation

**Internal state**
- Shift register `sh[n-1:0]`.
- Bit counter `cnt`, range 0..n-1, width `$clog2(n)`.
- Latched direction `dir`.

**Per rising edge of `C`, priority order**
1. **`R=1`:** `sh=0`, `cnt=0`, `dir=0`, `Q=0`, `nQ` = all ones, `V=0`, `OV=0`. All other inputs are ignored.
2. **`FR=1`:** `cnt=0`, partial word discarded.
   - If `SV=1` in the same cycle, that bit is taken as bit 1 of a new word, per step 3 with `cnt=0`.
   - `Q`, `V` and `OV` are unaffected.
3. **`SV=1`:**
   - If `cnt==0`, latch `dir=RTL`. The direction in effect is `RTL` itself on that edge and `dir` afterwards; `RTL` changes mid-word are ignored.
   - Shift: direction `1`: `sh <= {sh[n-2:0], SI}`; direction `0`: `sh <= {SI, sh[n-1:1]}`.
   - If `cnt==n-1`, the word completes: the completed value is the post-shift `sh`, and `cnt` wraps to 0. Otherwise `cnt` increments.
4. **Handshake, evaluated on the same edge:**
   - `ack = V & A`. An `A` pulse while `V=0` is ignored.
   - Word completes and (`V=0` or `ack`): `Q <= completed value`, `V <= 1`, `OV` unchanged.
   - Word completes, `V=1`, `A=0`: completed word dropped, `Q` and `V` held, `OV <= 1`.
   - No completion and `ack`: `V <= 0`, `Q` held.
5. **`OV`** clears only on `R`.

**`SV=0` cycles:** `sh`, `cnt` and `dir` hold. Gaps between bits are legal anywhere in a word.

**Outputs**
- `BUSY = (cnt != 0)`, derived combinationally from the register.
- `nQ` is derived from `Q`, so no separate state is needed.

## Timing

- **Latency:** the word is visible on `Q` with `V=1` immediately after the edge that samples its n-th valid bit. Minimum is n cycles from the first bit.
- **Throughput:** one word per n cycles with back-to-back `SV`, provided the consumer acks within n cycles.
- **Simultaneous completion and `ack`:** the new word replaces the old one and `V` stays 1 with no bubble. The consumer must treat `V` staying high after an ack as a new word.
- **`R` mid-word or mid-handshake:** everything returns to reset values on that edge.
- **`R` deasserted:** the first bit is accepted on the first following edge with `SV=1`.
- **`FR` on the completing edge:** completion does not occur; the bit starts a new word.

## Test plan

1. **MSB-first word:** reset, then `RTL=1`, n=4, `SI` = 1,0,1,1 on consecutive `SV` cycles → after the 4th edge `Q=4'b1011`, `nQ=4'b0100`, `V=1`, `BUSY=0`.
2. **LSB-first word:** `RTL=0`, `SI` = 1,0,1,1 → `Q=4'b1101`. Flipping `RTL` after the first bit does not change the result.
3. **Gaps and acknowledge:** insert `SV=0` gaps between bits → same `Q` as without gaps. `A=1` for one cycle → `V=0` next edge, `Q` held.
4. **Overflow:** complete word `4'h5` and leave it unacked, then complete `4'hA` → `Q` stays `4'h5`, `V=1`, `OV=1`. `OV` stays 1 after a later `A`.
5. **Back-to-back with ack:** `A=1` on the edge where word 2 completes → `Q` = word 2, `V` stays 1, `OV=0`.
6. **Restart and reset:** `FR` after 2 bits, then 4 bits `1,1,1,1` (`RTL=1`) → `Q=4'hF`. Then `R` asserted mid-word → `Q=0`, `nQ=4'hF`, `V=0`, `OV=0`, `BUSY=0`.
